// File: rtl/blur_pass_scheduler.sv
// Sequences one 3x3 blur pass: fetches each neighbourhood from BRAM, issues it, writes the result.
// Optional macro BLUR_CLAMP_EN: edge-replicate out-of-range taps (default: zero-pad, read skipped).
module blur_pass_scheduler #(
  parameter int unsigned WIDTH        = 128,
  parameter int unsigned HEIGHT       = 128,
  parameter int unsigned BIT_DEPTH    = 8,
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                   clk_in,
  input  logic                   rst_in_n,
  input  logic                   start_in,
  input  logic [ADDR_W-1:0]      src_base_in,
  input  logic [ADDR_W-1:0]      dst_base_in,
  output logic                   busy_out,
  output logic                   done_out,
  output logic [ADDR_W-1:0]      rd_addr_out,
  output logic                   rd_en_out,
  input  logic [BIT_DEPTH-1:0]   rd_data_in,
  output logic [3*BIT_DEPTH-1:0] r0_data_out,
  output logic [3*BIT_DEPTH-1:0] r1_data_out,
  output logic [3*BIT_DEPTH-1:0] r2_data_out,
  output logic                   blur_valid_out,
  input  logic [BIT_DEPTH-1:0]   blur_data_in,
  input  logic                   blur_valid_in,
  output logic [ADDR_W-1:0]      wr_addr_out,
  output logic [BIT_DEPTH-1:0]   wr_data_out,
  output logic                   wr_en_out
);
  localparam int unsigned XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [ADDR_W-1:0] WIDTH_A = ADDR_W'(WIDTH);

  typedef enum logic [2:0] {
    StIdle, StFetch, StDrain, StIssue, StWait, StWrite, StDone
  } state_e;

  state_e                r_state, w_state_d;
  logic [XW-1:0]         r_x, w_x_d;
  logic [YW-1:0]         r_y, w_y_d;
  logic [3:0]            r_tap, w_tap_d;
  logic [2:0]            r_cnt, w_cnt_d;
  logic [ADDR_W-1:0]     r_src, w_src_d, r_dst, w_dst_d;

  logic                  r_rd_en, w_rd_en_d;
  logic [ADDR_W-1:0]     r_rd_addr, w_rd_addr_d;
  logic                  r_wr_en, w_wr_en_d;
  logic [ADDR_W-1:0]     r_wr_addr, w_wr_addr_d;
  logic [BIT_DEPTH-1:0]  r_wr_data, w_wr_data_d;
  logic                  r_busy, r_done, r_blur_valid;
  logic [3*BIT_DEPTH-1:0] r_row0, r_row1, r_row2;

  // Capture pipeline: tap index and zero flag travel alongside each outstanding read
  logic                  r_pv   [READ_LATENCY];
  logic                  r_pz   [READ_LATENCY];
  logic [3:0]            r_ptap [READ_LATENCY];
  logic [BIT_DEPTH-1:0]  r_win  [9];
  logic [BIT_DEPTH-1:0]  w_win  [9];

  logic [1:0]            w_row, w_col;
  logic                  w_x_lo, w_x_hi, w_y_lo, w_y_hi;
  logic [XW-1:0]         w_tx;
  logic [YW-1:0]         w_ty;
`ifndef BLUR_CLAMP_EN
  logic                  w_oob;
`endif

  always_comb begin
    w_state_d   = r_state;
    w_x_d       = r_x;
    w_y_d       = r_y;
    w_tap_d     = r_tap;
    w_cnt_d     = r_cnt;
    w_src_d     = r_src;
    w_dst_d     = r_dst;
    w_wr_en_d   = 1'b0;
    w_wr_addr_d = '0;
    w_wr_data_d = '0;
    case (r_state)
      StIdle: begin
        if (start_in) begin
          w_state_d = StFetch;
          w_src_d   = src_base_in;
          w_dst_d   = dst_base_in;
          w_x_d     = '0;
          w_y_d     = '0;
          w_tap_d   = '0;
        end
      end
      StFetch: begin
        if (r_tap == 4'd8) begin
          w_state_d = StDrain;
          w_cnt_d   = '0;
        end else begin
          w_tap_d = r_tap + 4'd1;
        end
      end
      StDrain: begin
        if (r_cnt == 3'(READ_LATENCY - 1)) w_state_d = StIssue;
        else                               w_cnt_d   = r_cnt + 3'd1;
      end
      StIssue: w_state_d = StWait;
      StWait: begin
        if (blur_valid_in) begin
          w_state_d   = StWrite;
          w_wr_en_d   = 1'b1;
          w_wr_addr_d = r_dst + ADDR_W'(r_y) * WIDTH_A + ADDR_W'(r_x);
          w_wr_data_d = blur_data_in;
        end
      end
      StWrite: begin
        w_tap_d   = '0;
        w_state_d = StFetch;
        if (r_x == XW'(WIDTH - 1)) begin
          w_x_d = '0;
          if (r_y == YW'(HEIGHT - 1)) w_state_d = StDone;
          else                        w_y_d     = r_y + YW'(1);
        end else begin
          w_x_d = r_x + XW'(1);
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Geometry of the tap that will be on the read port next cycle
  always_comb begin
    w_row  = (w_tap_d >= 4'd6) ? 2'd2 : (w_tap_d >= 4'd3) ? 2'd1 : 2'd0;
    w_col  = 2'(w_tap_d - {1'b0, w_row, 1'b0} - {2'b00, w_row});
    w_x_lo = (w_col == 2'd0) && (w_x_d == '0);
    w_x_hi = (w_col == 2'd2) && (w_x_d == XW'(WIDTH - 1));
    w_y_lo = (w_row == 2'd0) && (w_y_d == '0);
    w_y_hi = (w_row == 2'd2) && (w_y_d == YW'(HEIGHT - 1));
    w_tx   = w_x_d;
    w_ty   = w_y_d;
    if (w_col == 2'd0 && !w_x_lo)      w_tx = w_x_d - XW'(1);
    else if (w_col == 2'd2 && !w_x_hi) w_tx = w_x_d + XW'(1);
    if (w_row == 2'd0 && !w_y_lo)      w_ty = w_y_d - YW'(1);
    else if (w_row == 2'd2 && !w_y_hi) w_ty = w_y_d + YW'(1);
`ifdef BLUR_CLAMP_EN
    w_rd_en_d = (w_state_d == StFetch);
`else
    w_oob     = w_x_lo | w_x_hi | w_y_lo | w_y_hi;
    w_rd_en_d = (w_state_d == StFetch) && !w_oob;
`endif
    w_rd_addr_d = w_rd_en_d ? (w_src_d + ADDR_W'(w_ty) * WIDTH_A + ADDR_W'(w_tx)) : '0;
  end

  // Window with this cycle's returning tap merged in, so ISSUE can load rows without a bubble
  always_comb begin
    w_win = r_win;
    if (r_pv[READ_LATENCY-1]) begin
      w_win[r_ptap[READ_LATENCY-1]] = r_pz[READ_LATENCY-1] ? '0 : rd_data_in;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      r_state      <= StIdle;
      r_x          <= '0;
      r_y          <= '0;
      r_tap        <= '0;
      r_cnt        <= '0;
      r_src        <= '0;
      r_dst        <= '0;
      r_rd_en      <= 1'b0;
      r_rd_addr    <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_blur_valid <= 1'b0;
      r_row0       <= '0;
      r_row1       <= '0;
      r_row2       <= '0;
      for (int i = 0; i < 9; i++) r_win[i] <= '0;
      for (int i = 0; i < int'(READ_LATENCY); i++) begin
        r_pv[i]   <= 1'b0;
        r_pz[i]   <= 1'b0;
        r_ptap[i] <= '0;
      end
    end else begin
      r_state      <= w_state_d;
      r_x          <= w_x_d;
      r_y          <= w_y_d;
      r_tap        <= w_tap_d;
      r_cnt        <= w_cnt_d;
      r_src        <= w_src_d;
      r_dst        <= w_dst_d;
      r_rd_en      <= w_rd_en_d;
      r_rd_addr    <= w_rd_addr_d;
      r_wr_en      <= w_wr_en_d;
      r_wr_addr    <= w_wr_addr_d;
      r_wr_data    <= w_wr_data_d;
      r_busy       <= (w_state_d != StIdle) && (w_state_d != StDone);
      r_done       <= (w_state_d == StDone);
      r_blur_valid <= (w_state_d == StIssue);
      r_win        <= w_win;
      r_pv[0]      <= (r_state == StFetch);
      r_pz[0]      <= !r_rd_en;
      r_ptap[0]    <= r_tap;
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        r_pv[i]   <= r_pv[i-1];
        r_pz[i]   <= r_pz[i-1];
        r_ptap[i] <= r_ptap[i-1];
      end
      if (w_state_d == StIssue) begin
        r_row0 <= {w_win[0], w_win[1], w_win[2]};
        r_row1 <= {w_win[3], w_win[4], w_win[5]};
        r_row2 <= {w_win[6], w_win[7], w_win[8]};
      end
    end
  end

  assign busy_out       = r_busy;
  assign done_out       = r_done;
  assign rd_en_out      = r_rd_en;
  assign rd_addr_out    = r_rd_addr;
  assign r0_data_out    = r_row0;
  assign r1_data_out    = r_row1;
  assign r2_data_out    = r_row2;
  assign blur_valid_out = r_blur_valid;
  assign wr_en_out      = r_wr_en;
  assign wr_addr_out    = r_wr_addr;
  assign wr_data_out    = r_wr_data;

endmodule

// File: tb/tb_blur_pass_scheduler.sv
// Scoreboard bench for blur_pass_scheduler on a 4x4 image; BRAM holds pixel = address low byte.
`timescale 1ns/1ps
module tb_blur_pass_scheduler;
  localparam int W = 4, H = 4, BD = 8, AW = 16, L = 2;

`ifdef BLUR_CLAMP_EN
  localparam bit          EXP_FIRST_RD = 1'b1;
  localparam int          EXP_EDGE_RD  = 9;
  localparam logic [23:0] E_R0 = 24'h000001, E_R1 = 24'h000001, E_R2 = 24'h040405;
`else
  localparam bit          EXP_FIRST_RD = 1'b0;
  localparam int          EXP_EDGE_RD  = 4;
  localparam logic [23:0] E_R0 = 24'h000000, E_R1 = 24'h000001, E_R2 = 24'h000405;
`endif

  logic clk_in = 1'b0, rst_in_n = 1'b0, start_in = 1'b0;
  logic [AW-1:0] src_base_in = '0, dst_base_in = '0;
  logic busy_out, done_out, rd_en_out, blur_valid_out, wr_en_out, blur_valid_in;
  logic [AW-1:0] rd_addr_out, wr_addr_out;
  logic [BD-1:0] rd_data_in, blur_data_in, wr_data_out;
  logic [3*BD-1:0] r0_data_out, r1_data_out, r2_data_out;

  int n_vec = 0, n_fail = 0, n_rd = 0, n_done = 0;
  logic [AW-1:0]    rd_q[$];
  logic [AW+BD-1:0] wr_q[$];

  always #5 clk_in = ~clk_in;

  blur_pass_scheduler #(
    .WIDTH(W), .HEIGHT(H), .BIT_DEPTH(BD), .ADDR_W(AW), .READ_LATENCY(L)
  ) dut (
    .clk_in(clk_in), .rst_in_n(rst_in_n), .start_in(start_in),
    .src_base_in(src_base_in), .dst_base_in(dst_base_in),
    .busy_out(busy_out), .done_out(done_out),
    .rd_addr_out(rd_addr_out), .rd_en_out(rd_en_out), .rd_data_in(rd_data_in),
    .r0_data_out(r0_data_out), .r1_data_out(r1_data_out), .r2_data_out(r2_data_out),
    .blur_valid_out(blur_valid_out), .blur_data_in(blur_data_in),
    .blur_valid_in(blur_valid_in),
    .wr_addr_out(wr_addr_out), .wr_data_out(wr_data_out), .wr_en_out(wr_en_out)
  );

  // BRAM model with READ_LATENCY pipeline; unread cycles return a poison value
  logic [AW-1:0] p_addr [L];
  logic          p_en   [L];
  always @(posedge clk_in) begin
    p_addr[0] <= rd_addr_out;
    p_en[0]   <= rd_en_out;
    for (int i = 1; i < L; i++) begin
      p_addr[i] <= p_addr[i-1];
      p_en[i]   <= p_en[i-1];
    end
  end
  assign rd_data_in = p_en[L-1] ? p_addr[L-1][BD-1:0] : 8'hEE;

  // Blur model: echoes the centre tap blur_delay cycles after each issue
  logic          blur_auto = 1'b0, auto_valid = 1'b0, man_valid = 1'b0;
  logic [BD-1:0] auto_data = '0, man_data = '0;
  int            blur_delay = 3;
  assign blur_valid_in = auto_valid | man_valid;
  assign blur_data_in  = auto_valid ? auto_data : man_data;

  always @(negedge clk_in) begin
    if (blur_auto && blur_valid_out) begin
      auto_data = r1_data_out[2*BD-1:BD];
      repeat (blur_delay) @(posedge clk_in);
      #1 auto_valid = 1'b1;
      @(posedge clk_in);
      #1 auto_valid = 1'b0;
    end
  end

  // Scoreboard monitors
  always @(negedge clk_in) begin
    if (rd_en_out) begin
      n_rd++;
      n_vec++;
      if (rd_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_unexpected: got read addr=%h, expected none", rd_addr_out);
      end else begin
        logic [AW-1:0] e;
        e = rd_q.pop_front();
        if (rd_addr_out !== e) begin
          n_fail++;
          $display("FAIL rd_addr: got %h expected %h", rd_addr_out, e);
        end
      end
    end
    if (wr_en_out) begin
      n_vec++;
      if (wr_q.size() == 0) begin
        n_fail++;
        $display("FAIL wr_unexpected: got addr=%h data=%h, expected none", wr_addr_out,
                 wr_data_out);
      end else begin
        logic [AW+BD-1:0] e;
        e = wr_q.pop_front();
        if ({wr_addr_out, wr_data_out} !== e) begin
          n_fail++;
          $display("FAIL wr: got addr=%h data=%h expected addr=%h data=%h", wr_addr_out,
                   wr_data_out, e[AW+BD-1:BD], e[BD-1:0]);
        end
      end
    end
    if (done_out) n_done++;
  end

  function automatic logic [BD-1:0] pix(input logic [AW-1:0] a);
    return a[BD-1:0];
  endfunction

  task automatic push_pass(input logic [AW-1:0] src, input logic [AW-1:0] dst,
                           output int n_reads);
    n_reads = 0;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        for (int t = 0; t < 9; t++) begin
          int tx, ty;
          bit inr;
          tx  = x + (t % 3) - 1;
          ty  = y + (t / 3) - 1;
          inr = (tx >= 0) && (tx < W) && (ty >= 0) && (ty < H);
`ifdef BLUR_CLAMP_EN
          tx  = (tx < 0) ? 0 : (tx > W - 1) ? W - 1 : tx;
          ty  = (ty < 0) ? 0 : (ty > H - 1) ? H - 1 : ty;
          inr = 1'b1;
`endif
          if (inr) begin
            rd_q.push_back(AW'(int'(src) + ty * W + tx));
            n_reads++;
          end
        end
        wr_q.push_back({AW'(int'(dst) + y * W + x), pix(AW'(int'(src) + y * W + x))});
      end
    end
  endtask

  task automatic do_start(input logic [AW-1:0] src, input logic [AW-1:0] dst);
    @(posedge clk_in);
    #1 src_base_in = src; dst_base_in = dst; start_in = 1'b1;
    @(posedge clk_in);
    #1 start_in = 1'b0;
  endtask

  task automatic wait_done(output bit seen, output bit wr_before, output bit busy_at);
    bit prev_wr = 1'b0;
    seen = 1'b0; wr_before = 1'b0; busy_at = 1'b1;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk_in);
      if (done_out) begin
        seen = 1'b1; wr_before = prev_wr; busy_at = busy_out;
      end
      prev_wr = wr_en_out;
    end
    repeat (4) @(negedge clk_in);
  endtask

  task automatic wait_issue(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 200 && cyc == 0; i++) begin
      @(negedge clk_in);
      if (blur_valid_out) cyc = i;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk_in);
    n_vec++;
    if ({busy_out, done_out, rd_en_out, wr_en_out, blur_valid_out} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 00000",
               {busy_out, done_out, rd_en_out, wr_en_out, blur_valid_out});
    end
    n_vec++;
    if ({rd_addr_out, wr_addr_out, wr_data_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_addr: got rd=%h wr=%h wd=%h expected 0", rd_addr_out, wr_addr_out,
               wr_data_out);
    end
    n_vec++;
    if ({r0_data_out, r1_data_out, r2_data_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_rows: got %h %h %h expected 0", r0_data_out, r1_data_out, r2_data_out);
    end
    @(posedge clk_in);
    #1 rst_in_n = 1'b1;
  endtask

  task automatic test_full_pass;
    int nr, rd0, d0;
    bit seen, wb, ba;
    blur_auto = 1'b1; blur_delay = 3;
    push_pass(16'h0000, 16'h0010, nr);
    rd0 = n_rd; d0 = n_done;
    do_start(16'h0000, 16'h0010);
    @(negedge clk_in);
    n_vec++;
    if (busy_out !== 1'b1) begin
      n_fail++; $display("FAIL full_busy: got %b expected 1", busy_out);
    end
    n_vec++;
    if (rd_en_out !== EXP_FIRST_RD) begin
      n_fail++; $display("FAIL full_first_rd: got %b expected %b", rd_en_out, EXP_FIRST_RD);
    end
    wait_done(seen, wb, ba);
    n_vec++;
    if (!seen || !wb || ba) begin
      n_fail++;
      $display("FAIL full_done: got seen=%b wr_before=%b busy=%b expected 1 1 0", seen, wb, ba);
    end
    n_vec++;
    if (n_done - d0 != 1 || n_rd - rd0 != nr) begin
      n_fail++;
      $display("FAIL full_counts: got done=%0d reads=%0d expected 1 %0d", n_done - d0,
               n_rd - rd0, nr);
    end
    n_vec++;
    if (wr_q.size() != 0 || rd_q.size() != 0) begin
      n_fail++;
      $display("FAIL full_leftover: got wr=%0d rd=%0d expected 0 0", wr_q.size(), rd_q.size());
    end
  endtask

  task automatic test_edge_pixel;
    int nr, rd0, cyc;
    bit seen, wb, ba;
    blur_auto = 1'b1; blur_delay = 2;
    push_pass(16'h0000, 16'h0010, nr);
    rd0 = n_rd;
    do_start(16'h0000, 16'h0010);
    wait_issue(cyc);
    n_vec++;
    if (cyc != 10 + L) begin
      n_fail++; $display("FAIL edge_issue_cycle: got %0d expected %0d", cyc, 10 + L);
    end
    n_vec++;
    if (r0_data_out !== E_R0 || r1_data_out !== E_R1 || r2_data_out !== E_R2) begin
      n_fail++;
      $display("FAIL edge_rows: got %h %h %h expected %h %h %h", r0_data_out, r1_data_out,
               r2_data_out, E_R0, E_R1, E_R2);
    end
    n_vec++;
    if (n_rd - rd0 != EXP_EDGE_RD) begin
      n_fail++; $display("FAIL edge_reads: got %0d expected %0d", n_rd - rd0, EXP_EDGE_RD);
    end
    @(negedge clk_in);
    n_vec++;
    if (blur_valid_out !== 1'b0 || r2_data_out !== E_R2) begin
      n_fail++;
      $display("FAIL edge_hold: got valid=%b r2=%h expected 0 %h", blur_valid_out, r2_data_out,
               E_R2);
    end
    wait_done(seen, wb, ba);
    n_vec++;
    if (!seen || wr_q.size() != 0) begin
      n_fail++; $display("FAIL edge_done: got seen=%b left=%0d expected 1 0", seen, wr_q.size());
    end
  endtask

  task automatic test_blur_wait;
    int nr, cyc, bad;
    bit seen, wb, ba;
    blur_auto = 1'b0;
    push_pass(16'h0020, 16'h0040, nr);
    do_start(16'h0020, 16'h0040);
    wait_issue(cyc);
    bad = 0;
    repeat (20) begin
      @(negedge clk_in);
      if (wr_en_out) bad++;
    end
    n_vec++;
    if (cyc == 0 || bad != 0) begin
      n_fail++; $display("FAIL wait_stall: got issue=%0d writes=%0d expected issue>0 0", cyc, bad);
    end
    @(posedge clk_in);
    #1 man_data = pix(16'h0020); man_valid = 1'b1;
    @(posedge clk_in);
    #1 man_valid = 1'b0;
    @(negedge clk_in);
    n_vec++;
    if (wr_en_out !== 1'b1) begin
      n_fail++; $display("FAIL wait_write_timing: got wr_en=%b expected 1", wr_en_out);
    end
    @(posedge clk_in);
    #1 man_data = 8'hAA; man_valid = 1'b1;
    @(posedge clk_in);
    #1 man_valid = 1'b0;
    blur_auto = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge clk_in);
      if (wr_en_out) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_fail++; $display("FAIL wait_stray_valid: got writes=%0d expected 0", bad);
    end
    wait_done(seen, wb, ba);
    n_vec++;
    if (!seen || wr_q.size() != 0) begin
      n_fail++; $display("FAIL wait_done: got seen=%b left=%0d expected 1 0", seen, wr_q.size());
    end
  endtask

  task automatic test_start_ignored_wrap;
    int nr;
    bit seen, wb, ba;
    blur_auto = 1'b1; blur_delay = 1;
    push_pass(16'hFFFF, 16'h0100, nr);
    do_start(16'hFFFF, 16'h0100);
    repeat (30) @(posedge clk_in);
    #1 src_base_in = 16'h0000; dst_base_in = 16'h0300; start_in = 1'b1;
    @(posedge clk_in);
    #1 start_in = 1'b0;
    @(negedge clk_in);
    n_vec++;
    if (busy_out !== 1'b1) begin
      n_fail++; $display("FAIL wrap_busy: got %b expected 1", busy_out);
    end
    wait_done(seen, wb, ba);
    n_vec++;
    if (!seen || wr_q.size() != 0 || rd_q.size() != 0) begin
      n_fail++;
      $display("FAIL wrap_done: got seen=%b wr=%0d rd=%0d expected 1 0 0", seen, wr_q.size(),
               rd_q.size());
    end
  endtask

  task automatic test_reset_mid;
    int nr, cyc, bad;
    bit seen, wb, ba;
    blur_auto = 1'b0;
    push_pass(16'h0000, 16'h0010, nr);
    do_start(16'h0000, 16'h0010);
    wait_issue(cyc);
    @(negedge clk_in);
    #1 rst_in_n = 1'b0;
    #1;
    n_vec++;
    if ({busy_out, blur_valid_out, wr_en_out, rd_en_out} !== 4'b0 || r1_data_out !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got ctrl=%b r1=%h expected 0 0",
               {busy_out, blur_valid_out, wr_en_out, rd_en_out}, r1_data_out);
    end
    man_data = 8'h77; man_valid = 1'b1;
    @(posedge clk_in);
    #1 man_valid = 1'b0;
    rd_q.delete();
    wr_q.delete();
    repeat (2) @(posedge clk_in);
    #1 rst_in_n = 1'b1;
    bad = 0;
    repeat (8) begin
      @(negedge clk_in);
      if (wr_en_out || busy_out) bad++;
    end
    n_vec++;
    if (cyc == 0 || bad != 0) begin
      n_fail++; $display("FAIL rstmid_quiet: got issue=%0d activity=%0d expected >0 0", cyc, bad);
    end
    blur_auto = 1'b1; blur_delay = 3;
    push_pass(16'h0000, 16'h0010, nr);
    do_start(16'h0000, 16'h0010);
    wait_done(seen, wb, ba);
    n_vec++;
    if (!seen || wr_q.size() != 0) begin
      n_fail++; $display("FAIL rstmid_restart: got seen=%b left=%0d expected 1 0", seen,
                         wr_q.size());
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_pass();
    test_edge_pixel();
    test_blur_wait();
    test_start_ignored_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
